// File: rtl/angle_range_reducer.sv
// angle_range_reducer: reduces an IEEE-754 single angle to r in [0, pi/2)
// plus quadrant q, using a 4.28 fixed-point restoring division by pi/2.
module angle_range_reducer #(
  parameter int W     = 32,
  parameter int W_Exp = 8,
  parameter int W_Sgf = 23
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         beg_reduce,
  input  logic         ack_reduce,
  input  logic [W-1:0] data_in,
  output logic         ready_reduce,
  output logic [W-1:0] data_output,
  output logic [1:0]   shift_region_flag,
  output logic         invalid_flag
);

  localparam logic [31:0] PI_2  = 32'h1921FB54;
  localparam logic [31:0] QNAN  = 32'h7FC00000;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DIV, S_ADJ, S_NORM, S_PACK, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       x_q, x_d;
  logic [31:0]        acc_q, acc_d;
  logic [3:0]         k_q, k_d;
  logic [1:0]         j_q, j_d;
  logic [1:0]         qi_q, qi_d;
  logic [4:0]         p_q, p_d;
  logic               inv_q, inv_d;
  logic               byp_q, byp_d;
  logic               ready_q, ready_d;
  logic [W-1:0]       out_q, out_d;
  logic [1:0]         q_q, q_d;
  logic               invf_q, invf_d;

  logic               sign;
  logic [W_Exp-1:0]   exp_f;
  logic [31:0]        mant_ext;
  logic [31:0]        conv;
  logic [31:0]        div_step;

  assign sign     = x_q[W-1];
  assign exp_f    = x_q[W-2 -: W_Exp];
  assign mant_ext = {8'd0, 1'b1, x_q[W_Sgf-1:0]};
  assign div_step = PI_2 << j_q;

  // |x| to 4.28 fixed point: {1,mant} shifted left by e+5 (e = exp-127)
  always_comb begin
    if (exp_f >= 8'd122) conv = mant_ext << (exp_f - 8'd122);
    else                 conv = mant_ext >> (8'd122 - exp_f);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (beg_reduce) state_d = S_LOAD;
      S_LOAD: state_d = S_DIV;
      S_DIV:  if (j_q == 2'd0) state_d = S_ADJ;
      S_ADJ:  state_d = S_NORM;
      S_NORM: state_d = S_PACK;
      S_PACK: state_d = S_DONE;
      S_DONE: if (ack_reduce) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state per stage
  always_comb begin
    x_d     = x_q;
    acc_d   = acc_q;
    k_d     = k_q;
    j_d     = j_q;
    qi_d    = qi_q;
    p_d     = p_q;
    inv_d   = inv_q;
    byp_d   = byp_q;
    ready_d = ready_q;
    out_d   = out_q;
    q_d     = q_q;
    invf_d  = invf_q;
    case (state_q)
      S_IDLE: if (beg_reduce) x_d = data_in;
      S_LOAD: begin
        acc_d = conv;
        k_d   = '0;
        j_d   = 2'd3;
        inv_d = (exp_f == 8'hFF) || (exp_f >= 8'd131);
        byp_d = !((exp_f == 8'hFF) || (exp_f >= 8'd131)) &&
                ((exp_f == 8'd0) || (exp_f < 8'd99) || (!sign && (conv < PI_2)));
      end
      S_DIV: begin
        if (acc_q >= div_step) begin
          acc_d    = acc_q - div_step;
          k_d[j_q] = 1'b1;
        end
        j_d = j_q - 2'd1;
      end
      S_ADJ: begin
        qi_d = k_q[1:0];
        if (sign) begin
          if (acc_q != '0) begin
            acc_d = PI_2 - acc_q;
            qi_d  = ~k_q[1:0];
          end else begin
            qi_d  = 2'd0 - k_q[1:0];
          end
        end
      end
      // Leading-one search is registered apart from the normalising shift
      S_NORM: begin
        p_d = '0;
        for (int unsigned i = 0; i < 32; i++) begin
          if (acc_q[i]) p_d = 5'(i);
        end
      end
      S_PACK: begin
        ready_d = 1'b1;
        if (inv_q) begin
          out_d  = QNAN;
          q_d    = '0;
          invf_d = 1'b1;
        end else if (byp_q) begin
          out_d  = x_q;
          q_d    = '0;
          invf_d = 1'b0;
        end else begin
          q_d    = qi_q;
          invf_d = 1'b0;
          if (acc_q == '0) out_d = '0;
          else out_d = {1'b0, ({3'd0, p_q} + 8'd99),
                        23'((acc_q << (5'd31 - p_q)) >> 8)};
        end
      end
      S_DONE: if (ack_reduce) ready_d = 1'b0;
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= '0;
      acc_q   <= '0;
      k_q     <= '0;
      j_q     <= '0;
      qi_q    <= '0;
      p_q     <= '0;
      inv_q   <= 1'b0;
      byp_q   <= 1'b0;
      ready_q <= 1'b0;
      out_q   <= '0;
      q_q     <= '0;
      invf_q  <= 1'b0;
    end else begin
      x_q     <= x_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      j_q     <= j_d;
      qi_q    <= qi_d;
      p_q     <= p_d;
      inv_q   <= inv_d;
      byp_q   <= byp_d;
      ready_q <= ready_d;
      out_q   <= out_d;
      q_q     <= q_d;
      invf_q  <= invf_d;
    end
  end

  assign ready_reduce      = ready_q;
  assign data_output       = out_q;
  assign shift_region_flag = q_q;
  assign invalid_flag      = invf_q;

endmodule
